// File: rtl/uart_multi.sv
// Full-duplex UART with 16x oversampling, optional parity and 1/2 stop bits.
// Define UART_MULTI_RX_FIFO_EN for a FIFO_DEPTH-entry RX FIFO; otherwise RX uses a single holding register.
module uart_multi #(
    parameter int DIV_BITS   = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DIV_BITS-1:0]  i_div,
    input  logic                 i_par_en,
    input  logic                 i_par_odd,
    input  logic                 i_stop2,
    input  logic                 i_rxd,
    output logic                 o_txd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_frerr,
    output logic                 o_parerr,
    output logic                 o_overrun,
    input  logic                 i_err_clr
);
    // state  | meaning
    // IDLE   | line idle; TX accepts data, RX waits for falling edge
    // START  | start bit (TX: waits for first tick before driving low)
    // DATA   | data bits, LSB first
    // PARITY | optional parity bit
    // STOP   | stop bit(s); RX leaves after sampling the first
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rxd_m, rxd_s, rxd_d, rx_fall;
    logic [DIV_BITS-1:0]  tx_div_cnt, rx_div_cnt;
    logic                 tx_tick, rx_tick;
    state_t               rx_state, tx_state;
    logic [3:0]           rx_tcnt, tx_tcnt;
    logic [2:0]           rx_idx, tx_idx;
    logic [DATA_BITS-1:0] rx_shift, tx_shift;
    logic                 rx_par, rx_par_en, rx_par_odd, rx_push;
    logic                 tx_par, tx_par_en, tx_stop2, tx_go, tx_stop_n;
    logic                 pop, push_ok, ovf_set;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= i_rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end
    assign rx_fall = rxd_d & ~rxd_s;

    assign tx_tick = (tx_div_cnt == '0);
    assign rx_tick = (rx_div_cnt == '0);

    // TX tick is free-running; RX tick phase restarts at each start edge
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tx_div_cnt <= '0;
            rx_div_cnt <= '0;
        end else begin
            tx_div_cnt <= tx_tick ? i_div : tx_div_cnt - 1'b1;
            if ((rx_state == S_IDLE && rx_fall) || rx_tick)
                rx_div_cnt <= i_div;
            else
                rx_div_cnt <= rx_div_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_state   <= S_IDLE;
            rx_tcnt    <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par     <= 1'b0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_push    <= 1'b0;
            o_frerr    <= 1'b0;
            o_parerr   <= 1'b0;
        end else begin
            o_frerr  <= 1'b0;
            o_parerr <= 1'b0;
            rx_push  <= 1'b0;
            case (rx_state)
                S_IDLE: if (rx_fall) begin
                    rx_state   <= S_START;
                    rx_tcnt    <= '0;
                    rx_par_en  <= i_par_en;
                    rx_par_odd <= i_par_odd;
                end
                S_START: if (rx_tick) begin
                    rx_tcnt <= rx_tcnt + 4'd1;
                    if (rx_tcnt == 4'd7 && rxd_s)
                        rx_state <= S_IDLE;
                    else if (rx_tcnt == 4'd15) begin
                        rx_state <= S_DATA;
                        rx_idx   <= '0;
                    end
                end
                S_DATA: if (rx_tick) begin
                    rx_tcnt <= rx_tcnt + 4'd1;
                    if (rx_tcnt == 4'd7)
                        rx_shift <= {rxd_s, rx_shift[DATA_BITS-1:1]};
                    if (rx_tcnt == 4'd15) begin
                        if (rx_idx == LAST_BIT)
                            rx_state <= rx_par_en ? S_PARITY : S_STOP;
                        else
                            rx_idx <= rx_idx + 3'd1;
                    end
                end
                S_PARITY: if (rx_tick) begin
                    rx_tcnt <= rx_tcnt + 4'd1;
                    if (rx_tcnt == 4'd7)
                        rx_par <= rxd_s;
                    if (rx_tcnt == 4'd15)
                        rx_state <= S_STOP;
                end
                S_STOP: if (rx_tick) begin
                    rx_tcnt <= rx_tcnt + 4'd1;
                    if (rx_tcnt == 4'd7) begin
                        rx_state <= S_IDLE;
                        if (!rxd_s)
                            o_frerr <= 1'b1;
                        else if (rx_par_en && (rx_par != (^rx_shift ^ rx_par_odd)))
                            o_parerr <= 1'b1;
                        else
                            rx_push <= 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tx_state  <= S_IDLE;
            tx_tcnt   <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            tx_par_en <= 1'b0;
            tx_stop2  <= 1'b0;
            tx_go     <= 1'b0;
            tx_stop_n <= 1'b0;
            o_txd     <= 1'b1;
            o_ready   <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: if (i_valid) begin
                    tx_state  <= S_START;
                    tx_shift  <= i_data;
                    tx_par    <= ^i_data ^ i_par_odd;
                    tx_par_en <= i_par_en;
                    tx_stop2  <= i_stop2;
                    tx_go     <= 1'b0;
                    o_ready   <= 1'b0;
                end
                S_START: if (tx_tick) begin
                    if (!tx_go) begin
                        tx_go   <= 1'b1;
                        tx_tcnt <= '0;
                        o_txd   <= 1'b0;
                    end else begin
                        tx_tcnt <= tx_tcnt + 4'd1;
                        if (tx_tcnt == 4'd15) begin
                            tx_state <= S_DATA;
                            tx_idx   <= '0;
                            o_txd    <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                end
                S_DATA: if (tx_tick) begin
                    tx_tcnt <= tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'd15) begin
                        if (tx_idx != LAST_BIT) begin
                            tx_idx   <= tx_idx + 3'd1;
                            o_txd    <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end else if (tx_par_en) begin
                            tx_state <= S_PARITY;
                            o_txd    <= tx_par;
                        end else begin
                            tx_state  <= S_STOP;
                            tx_stop_n <= 1'b0;
                            o_txd     <= 1'b1;
                        end
                    end
                end
                S_PARITY: if (tx_tick) begin
                    tx_tcnt <= tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'd15) begin
                        tx_state  <= S_STOP;
                        tx_stop_n <= 1'b0;
                        o_txd     <= 1'b1;
                    end
                end
                S_STOP: if (tx_tick) begin
                    tx_tcnt <= tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'd15) begin
                        if (tx_stop2 && !tx_stop_n)
                            tx_stop_n <= 1'b1;
                        else begin
                            tx_state <= S_IDLE;
                            o_ready  <= 1'b1;
                        end
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    assign pop = o_valid & i_ready;

`ifdef UART_MULTI_RX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 full;

    assign full    = (count == FULL_CNT);
    assign push_ok = rx_push & (~full | pop);
    assign ovf_set = rx_push & full & ~pop;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= rx_shift;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_valid = (count != '0);
    assign o_data  = mem[rd_ptr];
`else
    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_valid;

    assign push_ok = rx_push & (~hold_valid | pop);
    assign ovf_set = rx_push & hold_valid & ~pop;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (push_ok) begin
            hold_data  <= rx_shift;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign o_valid = hold_valid;
    assign o_data  = hold_data;
`endif

    // set wins over a simultaneous clear
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            o_overrun <= 1'b0;
        else if (ovf_set)
            o_overrun <= 1'b1;
        else if (i_err_clr)
            o_overrun <= 1'b0;
    end
endmodule

// File: tb/tb_uart_multi.sv
// Self-checking bench for uart_multi: TX waveform, loopback, error injection, overrun and mid-frame reset.
module tb_uart_multi;
    localparam int FD = 8;
`ifdef UART_MULTI_RX_FIFO_EN
    localparam int EFF_DEPTH = FD;
`else
    localparam int EFF_DEPTH = 1;
`endif

    logic        clk, rst_n;
    logic [15:0] div;
    logic        par_en, par_odd, stop2;
    logic        rxd_drv, loopback, rx_line, txd;
    logic [7:0]  rdata, tdata;
    logic        rvalid, rready, tvalid, tready;
    logic        frerr, parerr, overrun, err_clr;

    int          n_checks = 0;
    int          n_fail = 0;
    int          frerr_cnt = 0;
    int          parerr_cnt = 0;
    logic [7:0]  exp_q[$];

    assign rx_line = loopback ? txd : rxd_drv;

    uart_multi #(.DIV_BITS(16), .DATA_BITS(8), .FIFO_DEPTH(FD)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_div(div),
        .i_par_en(par_en), .i_par_odd(par_odd), .i_stop2(stop2),
        .i_rxd(rx_line), .o_txd(txd),
        .o_data(rdata), .o_valid(rvalid), .i_ready(rready),
        .i_data(tdata), .i_valid(tvalid), .o_ready(tready),
        .o_frerr(frerr), .o_parerr(parerr), .o_overrun(overrun), .i_err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: pops happen on the next rising edge when valid and ready
    always @(negedge clk) begin
        #1;
        if (rst_n === 1'b1) begin
            if (frerr === 1'b1) frerr_cnt++;
            if (parerr === 1'b1) parerr_cnt++;
            if (rvalid === 1'b1 && rready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rx_unexpected: got %02h, nothing expected", rdata);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rdata !== e) begin
                        n_fail++;
                        $display("FAIL rx_data: got %02h want %02h", rdata, e);
                    end
                end
            end
        end
    end

    task automatic send_tx(input logic [7:0] d);
        int n = 0;
        while (tready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_ready_timeout: ready %b want 1", tready);
        end
        tdata  = d;
        tvalid = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    task automatic inject(input logic [7:0] d, input bit has_par, input bit par_v,
                          input bit stop_v, input int bt);
        rxd_drv = 1'b0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = d[i];
            repeat (bt) @(negedge clk);
        end
        if (has_par) begin
            rxd_drv = par_v;
            repeat (bt) @(negedge clk);
        end
        rxd_drv = stop_v;
        repeat (bt) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (2 * bt) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d frames outstanding, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        n_checks++;
        if ({txd, tready, rvalid, frerr, parerr, overrun} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_flags: got txd,rdy,vld,fe,pe,ovr=%b want 110000",
                     {txd, tready, rvalid, frerr, parerr, overrun});
        end
        n_checks++;
        if (rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %02h want 00", rdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tx_a5();
        logic [9:0] bits;
        int bad;
        int n;
        bits = {1'b1, 8'hA5, 1'b0};
        div = 16'd0; par_en = 1'b0; stop2 = 1'b0; loopback = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tready !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_ready_idle: got %b want 1", tready);
        end
        tdata = 8'hA5; tvalid = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
        n_checks++;
        if ({tready, txd} !== 2'b01) begin
            n_fail++;
            $display("FAIL tx_after_xfer: got ready,txd=%b want 01", {tready, txd});
        end
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            repeat (16) begin
                @(negedge clk);
                if (txd !== bits[b]) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL tx_bit%0d: %0d of 16 samples wrong, want all %b", b, bad, bits[b]);
            end
        end
        n = 0;
        while (tready !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (tready !== 1'b1 || txd !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_ready_return: got ready,txd=%b%b want 11", tready, txd);
        end
    endtask

    task automatic test_loopback();
        int fe0, pe0;
        logic [7:0] vals [3];
        vals = '{8'h3C, 8'hFF, 8'h00};
        fe0 = frerr_cnt; pe0 = parerr_cnt;
        loopback = 1'b1; div = 16'd3; par_en = 1'b1; par_odd = 1'b0; stop2 = 1'b1; rready = 1'b1;
        foreach (vals[i]) begin
            exp_q.push_back(vals[i]);
            send_tx(vals[i]);
        end
        wait_drain(5000, "loopback_drain");
        n_checks++;
        if (frerr_cnt != fe0 || parerr_cnt != pe0) begin
            n_fail++;
            $display("FAIL loopback_errors: got fe=%0d pe=%0d want 0 0", frerr_cnt - fe0, parerr_cnt - pe0);
        end
    endtask

    task automatic test_parerr();
        int fe0, pe0;
        loopback = 1'b0; div = 16'd0; par_en = 1'b1; par_odd = 1'b0; stop2 = 1'b0; rready = 1'b0;
        repeat (4) @(negedge clk);
        fe0 = frerr_cnt; pe0 = parerr_cnt;
        inject(8'h01, 1'b1, 1'b0, 1'b1, 16);
        n_checks++;
        if (parerr_cnt - pe0 != 1 || frerr_cnt != fe0 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL parerr_frame: got pe=%0d fe=%0d valid=%b want 1 0 0",
                     parerr_cnt - pe0, frerr_cnt - fe0, rvalid);
        end
    endtask

    task automatic test_frerr_glitch();
        int fe0, pe0;
        par_en = 1'b0; div = 16'd0; rready = 1'b0;
        fe0 = frerr_cnt; pe0 = parerr_cnt;
        inject(8'h55, 1'b0, 1'b0, 1'b0, 16);
        n_checks++;
        if (frerr_cnt - fe0 != 1 || parerr_cnt != pe0 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL frerr_frame: got fe=%0d pe=%0d valid=%b want 1 0 0",
                     frerr_cnt - fe0, parerr_cnt - pe0, rvalid);
        end
        fe0 = frerr_cnt; pe0 = parerr_cnt;
        rxd_drv = 1'b0;
        repeat (8) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (48) @(negedge clk);
        n_checks++;
        if (frerr_cnt != fe0 || parerr_cnt != pe0 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_reject: got fe=%0d pe=%0d valid=%b want 0 0 0",
                     frerr_cnt - fe0, parerr_cnt - pe0, rvalid);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        loopback = 1'b0; div = 16'd0; par_en = 1'b0; rready = 1'b0;
        for (int k = 0; k <= EFF_DEPTH; k++) begin
            d = 8'(k * 8'h13 + 8'h5A);
            if (k < EFF_DEPTH) exp_q.push_back(d);
            inject(d, 1'b0, 1'b0, 1'b1, 16);
        end
        n_checks++;
        if (overrun !== 1'b1 || rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got ovr=%b valid=%b want 1 1", overrun, rvalid);
        end
        rready = 1'b1;
        wait_drain(100, "overrun_drain");
        repeat (3) @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_after_drain: got valid=%b ovr=%b want 0 1", rvalid, overrun);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
    endtask

    task automatic test_reset_mid();
        int fe0, pe0;
        loopback = 1'b1; div = 16'd0; par_en = 1'b0; stop2 = 1'b0; rready = 1'b1;
        @(negedge clk);
        send_tx(8'h96);
        repeat (72) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({txd, tready, rvalid} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_mid: got txd,ready,valid=%b want 110", {txd, tready, rvalid});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fe0 = frerr_cnt; pe0 = parerr_cnt;
        exp_q.push_back(8'h4B);
        send_tx(8'h4B);
        wait_drain(1000, "reset_mid_drain");
        n_checks++;
        if (frerr_cnt != fe0 || parerr_cnt != pe0) begin
            n_fail++;
            $display("FAIL reset_mid_errors: got fe=%0d pe=%0d want 0 0", frerr_cnt - fe0, parerr_cnt - pe0);
        end
    endtask

    initial begin
        div = 16'd0; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
        rxd_drv = 1'b1; loopback = 1'b0; rready = 1'b0;
        tdata = 8'h00; tvalid = 1'b0; err_clr = 1'b0;
        test_reset();
        test_tx_a5();
        test_loopback();
        test_parerr();
        test_frerr_glitch();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
